// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and per-cycle action encoding for the fetch stage
package fetch_pkg;

   localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ACT_ISSUE    = 2'd0,
      ACT_HOLD     = 2'd1,
      ACT_REDIRECT = 2'd2
   } fetch_act_e;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch bundle: execute redirect, decode stall, instruction BRAM port, decode input
interface fetch_if #(
   parameter int W = 14
);
   logic          f_stall;
   logic          redirect_valid;
   logic [W-1:0]  redirect_pc;
   logic          imem_en;
   logic [W-1:0]  imem_addr;
   logic [31:0]   imem_rdata;
   logic [W-1:0]  D_pc;
   logic [31:0]   instr_code;
   logic          D_valid;

   modport master (
      input  f_stall, redirect_valid, redirect_pc, imem_rdata,
      output imem_en, imem_addr, D_pc, instr_code, D_valid
   );

   modport slave (
      output f_stall, redirect_valid, redirect_pc, imem_rdata,
      input  imem_en, imem_addr, D_pc, instr_code, D_valid
   );
endinterface

// File: rtl/fetch_skid_reg.sv
// rtl/fetch_skid_reg.sv - captures the presented BRAM word when decode stalls and muxes it onto instr_code
module fetch_skid_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_hold,
   input  logic        i_rd_pending,
   input  logic [31:0] i_rdata,
   output logic        o_valid,
   output logic [31:0] o_instr
);
   logic        r_full;
   logic [31:0] r_instr;

   // Capture only on the first hold cycle; BRAM output is not trusted once imem_en drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full  <= 1'b0;
         r_instr <= '0;
      end else if (i_hold) begin
         if (!r_full) begin
            r_instr <= i_rdata;
            r_full  <= 1'b1;
         end
      end else begin
         r_full <= 1'b0;
      end
   end

   assign o_valid = r_full | i_rd_pending;
   assign o_instr = r_full ? r_instr : (i_rd_pending ? i_rdata : NOP_INSTR);
endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch: drives a 1-cycle BRAM, presents one instruction per cycle to decode
module fetch
   import fetch_pkg::*;
#(
   parameter int                          INSTR_ADDR_WIDTH = 14,
   parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_PC         = '0,
   parameter logic [31:0]                 NOP_INSTR        = FETCH_NOP_INSTR
) (
   input  logic     clk,
   input  logic     rst_n,
   fetch_if.master  bus
);
   localparam int W = INSTR_ADDR_WIDTH;
   localparam logic [W-1:0] PC_ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_f_pc;
   logic [W-1:0] r_d_pc;
   logic         r_rd_pending;
   logic         w_valid;
   logic         w_hold;
   fetch_act_e   w_act;

   fetch_skid_reg #(.NOP_INSTR(NOP_INSTR)) u_skid (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_hold       (w_act == ACT_HOLD),
      .i_rd_pending (r_rd_pending),
      .i_rdata      (bus.imem_rdata),
      .o_valid      (w_valid),
      .o_instr      (bus.instr_code)
   );

   // An empty decode slot never blocks issue, so a stall only holds while something is presented.
   assign w_hold = w_valid & bus.f_stall & ~bus.redirect_valid;

   always_comb begin
      w_act = ACT_ISSUE;
      if (bus.redirect_valid) w_act = ACT_REDIRECT;
      else if (w_hold)        w_act = ACT_HOLD;
   end

   assign bus.imem_addr = bus.redirect_valid ? bus.redirect_pc : r_f_pc;
   assign bus.imem_en   = rst_n & ~w_hold;
   assign bus.D_pc      = r_d_pc;
   assign bus.D_valid   = w_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_f_pc       <= RESET_PC;
         r_d_pc       <= '0;
         r_rd_pending <= 1'b0;
      end else begin
         case (w_act)
            ACT_REDIRECT: begin
               r_f_pc       <= bus.redirect_pc + PC_ONE;
               r_d_pc       <= bus.redirect_pc;
               r_rd_pending <= 1'b1;
            end
            ACT_HOLD: begin
               r_rd_pending <= 1'b0;
            end
            default: begin
               r_d_pc       <= r_f_pc;
               r_f_pc       <= r_f_pc + PC_ONE;
               r_rd_pending <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - scoreboard bench for fetch: directed stall/redirect/wrap/reset vectors plus a random stall/redirect run
module tb_fetch;
   localparam int W = 14;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst_n;

   fetch_if #(.W(W)) bus ();

   fetch #(.INSTR_ADDR_WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [W-1:0] a);
      return 32'h100 + {16'd0, a, 2'b00};
   endfunction

   // BRAM model; a disabled read returns junk so nothing may depend on the output holding.
   always @(posedge clk)
      bus.imem_rdata <= bus.imem_en ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W+31:0] exp_q[$];
   logic [W-1:0]  next_pc;
   logic          model_valid;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Monitor: every instruction decode takes (not flushed by a redirect) must match the queue head.
   always @(negedge clk) begin
      if (rst_n && bus.D_valid && !bus.f_stall && !bus.redirect_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: accepted D_pc %h, required no acceptance", bus.D_pc);
         end else begin
            logic [W+31:0] e;
            e = exp_q.pop_front();
            check("sb_d_pc", 32'(bus.D_pc), 32'(e[W+31:32]));
            check("sb_instr", bus.instr_code, e[31:0]);
         end
      end
   end

   // Apply one cycle's inputs and record what decode should accept in that cycle.
   task automatic drive(input logic stall, input logic redir, input logic [W-1:0] rpc);
      bus.f_stall        = stall;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      #1;
      if (redir) begin
         next_pc = rpc;
      end else if (model_valid && !stall) begin
         exp_q.push_back({next_pc, mem_word(next_pc)});
         next_pc = next_pc + 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rst_n) model_valid = 1'b1;
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.f_stall        = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      next_pc            = '0;
      model_valid        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_imem_en", 32'(bus.imem_en), 0);
      check("rst_d_valid", 32'(bus.D_valid), 0);
      check("rst_instr", bus.instr_code, NOP);
      check("rst_d_pc", 32'(bus.D_pc), 0);

      // 1: reset release, unstalled stream
      rst_n = 1'b1;
      drive(0, 0, '0);
      check("t1_addr0", 32'(bus.imem_addr), 0);
      check("t1_en0", 32'(bus.imem_en), 1);
      check("t1_valid0", 32'(bus.D_valid), 0);
      step();
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, '0);
         check("t1_d_pc", 32'(bus.D_pc), i);
         check("t1_instr", bus.instr_code, 32'h100 + 32'(i) * 4);
         check("t1_addr", 32'(bus.imem_addr), i + 1);
         step();
      end

      // 2: three-cycle stall with D_pc=5 presented
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, '0);
         check("t2_hold_pc", 32'(bus.D_pc), 5);
         check("t2_hold_instr", bus.instr_code, 32'h114);
         check("t2_hold_en", 32'(bus.imem_en), 0);
         step();
      end
      drive(0, 0, '0);
      check("t2_rel_pc", 32'(bus.D_pc), 5);
      check("t2_rel_addr", 32'(bus.imem_addr), 6);
      step();
      drive(0, 0, '0);
      check("t2_next_pc", 32'(bus.D_pc), 6);
      check("t2_next_instr", bus.instr_code, 32'h118);
      step();

      // 3: redirect while stalled with the skid full
      drive(1, 0, '0); step();
      drive(1, 0, '0); step();
      drive(1, 1, 14'h200);
      check("t3_en", 32'(bus.imem_en), 1);
      check("t3_addr", 32'(bus.imem_addr), 32'h200);
      step();
      drive(1, 0, '0);
      check("t3_d_pc", 32'(bus.D_pc), 32'h200);
      check("t3_instr", bus.instr_code, 32'h900);
      check("t3_valid", 32'(bus.D_valid), 1);
      step();
      drive(0, 0, '0); step();

      // 4: redirect to the top word address wraps
      drive(0, 1, 14'h3FFF); step();
      drive(0, 0, '0); check("t4_pc_top", 32'(bus.D_pc), 32'h3FFF); step();
      drive(0, 0, '0); check("t4_pc_wrap", 32'(bus.D_pc), 0); step();
      drive(0, 0, '0); check("t4_pc_one", 32'(bus.D_pc), 1); step();

      // 5: asynchronous reset with the skid full
      drive(1, 0, '0); step();
      drive(1, 0, '0); step();
      drive(1, 0, '0);
      rst_n = 1'b0;
      #1;
      check("t5_en", 32'(bus.imem_en), 0);
      check("t5_valid", 32'(bus.D_valid), 0);
      check("t5_instr", bus.instr_code, NOP);
      model_valid = 1'b0;
      next_pc     = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1, 0, '0);
      check("t5_restart_en", 32'(bus.imem_en), 1);
      check("t5_restart_addr", 32'(bus.imem_addr), 0);
      step();
      drive(0, 0, '0);
      check("t5_restart_pc", 32'(bus.D_pc), 0);
      check("t5_restart_instr", bus.instr_code, 32'h100);
      step();

      // 6: random stalls and redirects against the sequential/redirect order
      for (int i = 0; i < 400; i++) begin
         logic st, rd;
         st = ($urandom_range(0, 9) < 3);
         rd = ($urandom_range(0, 9) == 0);
         drive(st, rd, W'($urandom));
         step();
      end
      drive(0, 0, '0); step();
      drive(0, 0, '0); step();

      check("sb_drain", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
